// File: rtl/pi_txn_master.sv
`timescale 1ns/1ps
// Parallel-interface transaction master: turns mem/status requests into
// timed SETUP/STROBE/HOLD register accesses and returns one response each.
module pi_txn_master #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        PI_CLK,
  input  logic        PI_RESET_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic        req_byte,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  PI_A,
  output logic        PI_RD,
  output logic        PI_WR,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  input  logic [15:0] PI_D_IN,
  input  logic        PI_TXN_IN_PROGRESS
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  // Synchronized TXN level is not trusted until this many WAIT clocks elapsed.
  localparam logic [CNT_W-1:0] IGNORE_CYC  = CNT_W'(4);

  localparam logic [1:0] KIND_MEM_RD = 2'd0;
  localparam logic [1:0] KIND_MEM_WR = 2'd1;
  localparam logic [1:0] KIND_ST_RD  = 2'd2;
  localparam logic [1:0] KIND_ST_WR  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_WAIT, ST_RESP
  } state_t;

  typedef enum logic [2:0] {
    ACC_WR_DATA, ACC_WR_ADDR_LO, ACC_WR_ADDR_HI, ACC_RD_DATA, ACC_STATUS
  } acc_t;

  // Direction of the register access currently being sequenced.
  function automatic logic acc_is_wr(input acc_t acc, input logic [1:0] kind);
    case (acc)
      ACC_RD_DATA: acc_is_wr = 1'b0;
      ACC_STATUS:  acc_is_wr = (kind == KIND_ST_WR);
      default:     acc_is_wr = 1'b1;
    endcase
  endfunction

  // Register address driven on PI_A for each access.
  function automatic logic [1:0] acc_addr(input acc_t acc);
    case (acc)
      ACC_WR_ADDR_LO: acc_addr = 2'd1;
      ACC_WR_ADDR_HI: acc_addr = 2'd2;
      ACC_STATUS:     acc_addr = 2'd3;
      default:        acc_addr = 2'd0;
    endcase
  endfunction

  // Data word driven on PI_D_OUT for each access (zero for reads).
  function automatic logic [15:0] acc_data(input acc_t acc, input logic [1:0] kind,
                                           input logic byt, input logic [23:0] addr,
                                           input logic [15:0] wdata);
    case (acc)
      ACC_WR_DATA:    acc_data = byt ? {wdata[7:0], wdata[7:0]} : wdata;
      ACC_WR_ADDR_LO: acc_data = addr[15:0];
      ACC_WR_ADDR_HI: acc_data = {6'b0, (kind == KIND_MEM_RD), byt, addr[23:16]};
      ACC_STATUS:     acc_data = (kind == KIND_ST_WR) ? wdata : 16'h0000;
      default:        acc_data = 16'h0000;
    endcase
  endfunction

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              zero_q, zero_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        kind_q, kind_d;
  logic              byte_q, byte_d;
  logic [23:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              sync1_q, sync2_q;

  logic              in_acc_d;
  logic              wr_acc_d;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic [15:0]       rsp_rdata_d;
  logic              rsp_err_d;
  logic [1:0]        pi_a_d;
  logic              pi_rd_d;
  logic              pi_wr_d;
  logic [15:0]       pi_d_out_d;
  logic              pi_d_oe_d;

  // Two-flop synchronizer for the asynchronous transaction-busy level.
  always_ff @(posedge PI_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PI_TXN_IN_PROGRESS;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, phase/timeout counting and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    timeout_d   = timeout_q;
    kind_d      = kind_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_rdata_d = 16'h0000;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          kind_d    = req_kind;
          byte_d    = req_byte;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_SETUP;
          case (req_kind)
            KIND_MEM_WR: acc_d = ACC_WR_DATA;
            KIND_MEM_RD: acc_d = ACC_WR_ADDR_LO;
            default:     acc_d = ACC_STATUS;
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          if (!acc_is_wr(acc_q, kind_q)) begin
            rdata_d = PI_D_IN;
          end
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          case (acc_q)
            ACC_WR_DATA: begin
              acc_d   = ACC_WR_ADDR_LO;
              state_d = ST_SETUP;
            end
            ACC_WR_ADDR_LO: begin
              acc_d   = ACC_WR_ADDR_HI;
              state_d = ST_SETUP;
            end
            ACC_WR_ADDR_HI: begin
              zero_d  = 1'b0;
              state_d = ST_WAIT;
            end
            default: state_d = ST_RESP;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if ((cnt_q >= IGNORE_CYC) && !sync2_q && zero_q) begin
          cnt_d = '0;
          if (kind_q == KIND_MEM_RD) begin
            acc_d   = ACC_RD_DATA;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
          end
        end else if (cnt_q == TIMEOUT_VAL) begin
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          zero_d = (cnt_q >= IGNORE_CYC) && !sync2_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RESP) begin
      if (timeout_d) begin
        rsp_rdata_d = 16'hFFFF;
        rsp_err_d   = 1'b1;
      end else begin
        case (kind_d)
          KIND_MEM_RD: begin
            if (byte_d) begin
              rsp_rdata_d = addr_d[0] ? {8'h00, rdata_d[7:0]} : {8'h00, rdata_d[15:8]};
            end else begin
              rsp_rdata_d = rdata_d;
            end
          end
          KIND_ST_RD: rsp_rdata_d = rdata_d;
          default:    rsp_rdata_d = 16'h0000;
        endcase
      end
    end

    in_acc_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    wr_acc_d    = acc_is_wr(acc_d, kind_d);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    pi_a_d      = in_acc_d ? acc_addr(acc_d) : 2'd0;
    pi_d_out_d  = in_acc_d ? acc_data(acc_d, kind_d, byte_d, addr_d, wdata_d) : 16'h0000;
    pi_d_oe_d   = in_acc_d && wr_acc_d;
    pi_rd_d     = (state_d == ST_STROBE) && !wr_acc_d;
    pi_wr_d     = (state_d == ST_STROBE) && wr_acc_d;
  end

  // State, request capture and registered outputs.
  always_ff @(posedge PI_CLK or negedge PI_RESET_n) begin
    if (!PI_RESET_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= ACC_WR_DATA;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      timeout_q <= 1'b0;
      kind_q    <= 2'd0;
      byte_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PI_A      <= 2'd0;
      PI_RD     <= 1'b0;
      PI_WR     <= 1'b0;
      PI_D_OUT  <= '0;
      PI_D_OE   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      timeout_q <= timeout_d;
      kind_q    <= kind_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      PI_A      <= pi_a_d;
      PI_RD     <= pi_rd_d;
      PI_WR     <= pi_wr_d;
      PI_D_OUT  <= pi_d_out_d;
      PI_D_OE   <= pi_d_oe_d;
    end
  end

endmodule

// File: doc/pi_txn_master.md
PI_TXN_MASTER -- requirements
Module: pi_txn_master

Interface
REG-parameters:
REQ-001 The block SHALL have parameter SETUP_CYC, default 2: clocks that PI_A/PI_D are stable before a strobe rises.
REQ-002 The block SHALL have parameter STROBE_CYC, default 4: clocks that PI_RD/PI_WR stay high.
REQ-003 The block SHALL have parameter HOLD_CYC, default 2: clocks that PI_A/PI_D are held after a strobe falls.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 65535: maximum clocks spent in WAIT_TXN.
Ports:
REQ-005 The block SHALL have PI_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have PI_RESET_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have req_valid/req_ready, input/output, 1 bit each: request handshake.
REQ-008 The block SHALL have req_kind, input, 2 bits: 0 mem-read, 1 mem-write, 2 status-read, 3 status-write.
REQ-009 The block SHALL have req_byte, input, 1 bit: byte access when 1.
REQ-010 The block SHALL have req_addr, input, 24 bits, and req_wdata, input, 16 bits.
REQ-011 The block SHALL have rsp_valid, output, 1 bit: a one-clock pulse; rsp_rdata, output, 16 bits; rsp_err, output, 1 bit.
REQ-012 The block SHALL have PI_A, output, 2 bits; PI_RD and PI_WR, outputs, 1 bit each.
REQ-013 The block SHALL have PI_D_OUT, output, 16 bits; PI_D_OE, output, 1 bit; PI_D_IN, input, 16 bits.
REQ-014 The block SHALL have PI_TXN_IN_PROGRESS, input, 1 bit; it is asynchronous to PI_CLK.

Function
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock where req_valid and req_ready are both 1, and all req_* fields are captured on that clock.
REQ-016 Each register access SHALL run three phases: SETUP for SETUP_CYC clocks (PI_A and PI_D_OUT valid, strobe 0), STROBE for STROBE_CYC clocks (strobe 1), then HOLD for HOLD_CYC clocks (strobe 0, PI_A and PI_D_OUT unchanged).
REQ-017 PI_D_OE SHALL be 1 during all three phases of a write access and 0 at every other time; PI_RD and PI_WR SHALL never be 1 in the same clock.
REQ-018 A read access SHALL sample PI_D_IN on the last STROBE clock.
REQ-019 Mem-write sequence: WR_DATA (PI_A=0, wdata), WR_ADDR_LO (PI_A=1, addr[15:0]), WR_ADDR_HI (PI_A=2, {6'b0, rw=0, byte, addr[23:16]}), WAIT_TXN, RESP.
REQ-020 Mem-read sequence: WR_ADDR_LO, WR_ADDR_HI with rw=1 (bit 9), WAIT_TXN, RD_DATA (PI_A=0), RESP.
REQ-021 Status-write SHALL be a single write access to PI_A=3 with wdata, followed by RESP; status-read SHALL be a single read access to PI_A=3, followed by RESP; neither enters WAIT_TXN.
REQ-022 PI_TXN_IN_PROGRESS SHALL pass through a 2-flop synchronizer; WAIT_TXN SHALL exit when the synchronized value is 0 for 2 consecutive clocks.
REQ-023 WAIT_TXN SHALL ignore the synchronized value for its first 4 clocks, so that a stale 0 is not taken as completion.
REQ-024 A 16-bit timeout counter SHALL clear on entry to WAIT_TXN; when it reaches TIMEOUT_CYC, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=16'hFFFF, skipping RD_DATA.
REQ-025 For a byte mem-read, rsp_rdata SHALL be {8'h00, D[15:8]} when addr[0]=0 and {8'h00, D[7:0]} when addr[0]=1; a word read SHALL return D unchanged.
REQ-026 A byte mem-write SHALL place wdata[7:0] on both D bytes.
REQ-027 For write kinds, rsp_rdata SHALL be 0.
REQ-028 RESP SHALL last exactly one clock, with rsp_valid=1, then return to IDLE; the response is not back-pressured.
REQ-029 Mem-access latency from acceptance to rsp_valid, excluding WAIT_TXN, SHALL be N*(SETUP_CYC+STROBE_CYC+HOLD_CYC)+1 clocks, where N is the number of accesses (3 for a write, 3 for a read).
REQ-030 req_valid asserted outside IDLE SHALL be ignored; the request is held by the requester.

Reset
REQ-031 PI_RESET_n low SHALL immediately force IDLE and set PI_RD=0, PI_WR=0, PI_D_OE=0, PI_A=0, PI_D_OUT=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, and clear the synchronizer and counters.
REQ-032 After reset releases, req_ready SHALL become 1 on the first clock; a reset during an access SHALL abort it without producing a response.

Verification
REQ-033 Word write, addr=24'h123456, wdata=16'hBEEF, default parameters -> bus writes PI_A=0/BEEF, PI_A=1/3456, PI_A=2/0012, with TXN held 1 for 20 clocks; rsp_valid pulses once, rsp_err=0.
REQ-034 Byte read, addr=24'hBFE001, PI_D_IN=16'hA55A -> ADDR_HI word 0x03BF; rsp_rdata=16'h005A; repeat with addr=24'hBFE000 -> 16'h00A5.
REQ-035 Status-write 16'h0002, then status-read with PI_D_IN=16'hE000 -> one access each, no WAIT_TXN, rsp_rdata=16'hE000.
REQ-036 TXN held 1 with TIMEOUT_CYC=100 -> rsp_err=1, rsp_rdata=16'hFFFF, no PI_A=0 read; the next request completes normally.
REQ-037 PI_RESET_n pulsed low during the STROBE of WR_ADDR_LO -> PI_WR=0 within the same cycle, no rsp_valid, req_ready=1 on the first clock after release.
REQ-038 A checker SHALL verify, on all runs, that PI_RD and PI_WR are never both 1 and that PI_A/PI_D_OUT are stable from SETUP through HOLD.
